multicycle_core: RTL
====================

# multicycle_core

Parametrised multi-cycle processor core with external instruction and data memories reached through request/acknowledge handshakes. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK states, so memories of any latency can be attached. It also provides an internal register file, a HALT instruction, a retired-instruction counter and an asynchronous reset. It is the top-level compute block and replaces the fixed-width, fixed-latency core.

## Interface
- DATA_W, 32, datapath and register width (>= 8)
- PC_W, 8, instruction address width (<= 14)
- DADDR_W, 8, data address width (<= 14)
- CNT_W, 16, retired-instruction counter width
- RESET_PC, 0, PC value loaded by reset
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_addr  out  PC_W  fetch address (= pc)
- imem_req  out  1  fetch request
- imem_ack  in  1  fetch data valid this cycle
- imem_rdata  in  32  instruction word
- dmem_addr  out  DADDR_W  data address
- dmem_req  out  1  data request
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req
- dmem_wdata  out  DATA_W  store data
- dmem_ack  in  1  data access complete / load data valid
- dmem_rdata  in  DATA_W  load data
- halted  out  1  core stopped by HALT
- retired  out  CNT_W  count of completed instructions

## Operation
- Instruction fields:
  - [31:29] op
  - [28:24] rd
  - [23:19] rs1
  - [18:14] rs2
  - [13:0] addr
- Branch targets use addr[PC_W-1:0]; data addresses use addr[DADDR_W-1:0].
- Register file: 32 x DATA_W, all zero on reset. r0 always reads 0 and writes to it are discarded.
- Opcodes:
  - 0 LD: rd <= dmem[addr]
  - 1 ST: dmem[addr] <= rs1
  - 2 ADD: rd <= rs1+rs2
  - 3 SUB: rd <= rs1-rs2
  - 4 AND
  - 5 OR
  - 6 BEQ: if rs1==rs2 then pc <= addr
  - 7 HALT
- Arithmetic wraps modulo 2^DATA_W; there are no flags.
- States and transitions:
  - FETCH: imem_req=1. On imem_ack, capture imem_rdata, pc <= pc+1 (wraps mod 2^PC_W), go to DECODE.
  - DECODE: latch op, rd, addr and the register operands rs1/rs2, go to EXECUTE.
  - EXECUTE: register the ALU result.
    - ADD..OR go to WRITEBACK.
    - LD and ST go to MEM.
    - BEQ loads pc if taken, then goes to FETCH.
    - HALT goes to HALT.
  - MEM: dmem_req=1; dmem_we=1 for ST; dmem_wdata = latched rs1. The request is held until dmem_ack.
    - LD captures dmem_rdata on the ack and goes to WRITEBACK.
    - ST goes to FETCH on the ack.
  - WRITEBACK: write the result to rd, go to FETCH.
  - HALT: terminal. halted=1, no requests. Only rst leaves this state.
- retired increments by 1 in the cycle an instruction leaves its last state:
  - WRITEBACK
  - MEM for ST
  - EXECUTE for BEQ
  - EXECUTE for HALT
  - retired wraps mod 2^CNT_W.
- imem_ack and dmem_ack are ignored outside FETCH and MEM respectively.

## Timing
- Reset (asynchronous, immediate):
  - state = FETCH, pc = RESET_PC, registers = 0, retired = 0, halted = 0.
  - imem_req, dmem_req and dmem_we are gated to 0 while rst is high.
  - imem_addr = RESET_PC.
- The first fetch request is asserted in the first cycle after rst deasserts.
- imem_addr, dmem_addr and dmem_wdata are stable for the whole time their req is high.
- Latency with the ack given in the first request cycle:
  - ALU op: 4 cycles
  - LD: 5 cycles
  - ST: 4 cycles
  - BEQ: 3 cycles
  - HALT: 3 cycles to halted=1
- Each extra wait cycle before an ack adds exactly 1 cycle.
- Back-to-back: the FETCH for the next instruction begins the cycle after the previous instruction retires.
- Register reads in DECODE see any write completed in an earlier WRITEBACK; there is no hazard window.
- Reset mid-operation: an outstanding request is dropped immediately, any pending store is not issued, and any pending register write is lost.
- pc = 2^PC_W-1 fetches, then wraps to 0.

## Test plan
- Reset then run with zero-wait memories:
  - dmem[1]=5, dmem[2]=7; program LD r1,1; LD r2,2; ADD r3,r1,r2; ST r3,3; HALT.
  - Required: dmem[3]=12, retired=5, halted=1 after 4+5+5+4+3 = 21 cycles.
- Wait states: imem_ack delayed 3 cycles and dmem_ack delayed 2 cycles on the same program.
  - Required: same results, completion 5·3+3·2 = 21 cycles later.
  - Required: req and address held constant throughout every wait.
- Branch:
  - Program with r1=r2=9: BEQ r1,r2,#10 must fetch address 10 next.
  - Program with r1=9, r2=8: BEQ must fetch pc+1 next.
  - retired increments once in each case.
- Arithmetic edges with DATA_W=32:
  - SUB 0-1 gives 0xFFFFFFFF.
  - ADD with rd=r0 leaves r0 reading 0.
  - pc wrap: fetch at 0xFF, the next fetch is at 0x00.
- Reset mid-MEM:
  - Assert rst during a ST while dmem_ack=0.
  - Required: dmem_req drops in the same cycle, no store is seen, pc=RESET_PC, retired=0, and the next fetch is at RESET_PC.
- Halt hold: after HALT, toggle imem_ack and dmem_ack for 20 cycles.
  - Required: no req asserted; halted, retired and pc unchanged.

Source files
------------

// File: rtl/multicycle_core.sv
// Multi-cycle processor core: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer with
// handshaked instruction/data memories, a 32-entry register file and HALT.
module multicycle_core #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned PC_W     = 8,
    parameter int unsigned DADDR_W  = 8,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    imem_addr,
    output logic               imem_req,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic               dmem_ack,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic               halted,
    output logic [CNT_W-1:0]   retired
);
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned NREGS   = 32;
    localparam int unsigned RIDX_W  = 5;
    localparam int unsigned FADDR_W = 14;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_BEQ, OP_HALT
    } op_t;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q;
    logic [INSTR_W-1:0]  ir_q;
    op_t                 op_q;
    logic [RIDX_W-1:0]   rd_q;
    logic [FADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]   a_q, b_q, result_q;
    logic [CNT_W-1:0]    retired_q;
    logic [DATA_W-1:0]   regs_q [NREGS];
    logic                retire_c;
    logic [DATA_W-1:0]   alu_c;
    op_t                 ir_op;
    logic                unused_addr;

    assign ir_op       = op_t'(ir_q[31:29]);
    // Upper address bits are only partly consumed when PC_W/DADDR_W < 14.
    assign unused_addr = ^addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        retire_c = 1'b0;
        case (state_q)
            S_FETCH:   if (imem_ack) state_d = S_DECODE;
            S_DECODE:  state_d = S_EXECUTE;
            S_EXECUTE: begin
                case (op_q)
                    OP_LD, OP_ST: state_d = S_MEM;
                    OP_BEQ: begin
                        state_d  = S_FETCH;
                        retire_c = 1'b1;
                    end
                    OP_HALT: begin
                        state_d  = S_HALT;
                        retire_c = 1'b1;
                    end
                    default: state_d = S_WRITEBACK;
                endcase
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (op_q == OP_ST) begin
                        state_d  = S_FETCH;
                        retire_c = 1'b1;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end
            end
            S_WRITEBACK: begin
                state_d  = S_FETCH;
                retire_c = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        alu_c = '0;
        case (op_q)
            OP_ADD:  alu_c = a_q + b_q;
            OP_SUB:  alu_c = a_q - b_q;
            OP_AND:  alu_c = a_q & b_q;
            OP_OR:   alu_c = a_q | b_q;
            default: alu_c = '0;
        endcase
    end

    // Datapath registers; r0 is never written so it always reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= PC_W'(RESET_PC);
            ir_q      <= '0;
            op_q      <= OP_LD;
            rd_q      <= '0;
            addr_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            retired_q <= '0;
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            if (retire_c) retired_q <= retired_q + CNT_W'(1);
            case (state_q)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir_q <= imem_rdata;
                        pc_q <= pc_q + PC_W'(1);
                    end
                end
                S_DECODE: begin
                    op_q   <= ir_op;
                    rd_q   <= ir_q[28:24];
                    addr_q <= ir_q[13:0];
                    a_q    <= regs_q[ir_q[23:19]];
                    b_q    <= regs_q[ir_q[18:14]];
                end
                S_EXECUTE: begin
                    result_q <= alu_c;
                    if (op_q == OP_BEQ && a_q == b_q) pc_q <= addr_q[PC_W-1:0];
                end
                S_MEM: begin
                    if (dmem_ack && op_q == OP_LD) result_q <= dmem_rdata;
                end
                S_WRITEBACK: begin
                    if (rd_q != '0) regs_q[rd_q] <= result_q;
                end
                default: ;
            endcase
        end
    end

    // Requests are gated by rst so an outstanding access drops immediately.
    assign imem_addr  = pc_q;
    assign imem_req   = (state_q == S_FETCH) && !rst;
    assign dmem_req   = (state_q == S_MEM) && !rst;
    assign dmem_we    = dmem_req && (op_q == OP_ST);
    assign dmem_addr  = addr_q[DADDR_W-1:0];
    assign dmem_wdata = a_q;
    assign halted     = (state_q == S_HALT);
    assign retired    = retired_q;

endmodule
